// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl: one prescaled hold timer shared round-robin among N_REQ requesters.
// A requester raises req[i] with a duration (in ticks) on dur[i*DUR_W +: DUR_W];
// the block grants one channel at a time, times the hold, then pulses done/aborted.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req[N_REQ]     level request per channel, held until done/aborted
//   dur            packed per-channel durations in ticks (latched at grant)
//   abort          cancels the current hold (ignored when idle)
//   grant[N_REQ]   one-hot, high for the whole hold
//   busy           high while a hold is running or finishing
//   done[N_REQ]    one-cycle pulse on normal completion
//   aborted[N_REQ] one-cycle pulse on cancel or request drop
module timer_share_ctrl #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DUR_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] dur,
    input  logic                   abort,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       aborted
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(N_REQ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    // Elaboration-time parameter checks
    if ((CLK_HZ % TICK_HZ) != 0 || TICK_DIV < 1) begin : g_bad_tick_div
        $error("timer_share_ctrl: CLK_HZ/TICK_HZ must be an exact integer >= 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("timer_share_ctrl: N_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    aborted_q, aborted_d;

    logic                arb_found;
    logic [IDX_W-1:0]    arb_sel;
    logic [IDX_W-1:0]    arb_idx;
    int unsigned         arb_pos;
    logic [DUR_W-1:0]    arb_dur;
    logic                tick_wrap;
    logic                terminal;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first pending channel searching upward from ptr+1, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        arb_pos   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            arb_pos = (32'(ptr_q) + k) % N_REQ;
            arb_idx = IDX_W'(arb_pos);
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
        arb_dur = dur[32'(arb_sel)*DUR_W +: DUR_W];
    end

    assign tick_wrap = (presc_q == PRESC_LAST);
    // Last clock of the last tick; completion beats a coincident abort/drop
    assign terminal  = tick_wrap && (rem_q == DUR_W'(1));

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        presc_d   = presc_q;
        rem_d     = rem_q;
        grant_d   = '0;
        busy_d    = 1'b0;
        done_d    = '0;
        aborted_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    win_d   = arb_sel;
                    rem_d   = arb_dur;
                    presc_d = '0;
                    busy_d  = 1'b1;
                    if (arb_dur != '0) begin
                        state_d = ST_RUN;
                        grant_d = onehot(arb_sel);
                    end else begin
                        // Zero-length hold completes without ever granting
                        state_d = ST_FIN;
                        done_d  = onehot(arb_sel);
                    end
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (terminal) begin
                    state_d = ST_FIN;
                    done_d  = onehot(win_q);
                    presc_d = '0;
                    rem_d   = rem_q - DUR_W'(1);
                end else if (abort || !req[win_q]) begin
                    state_d   = ST_FIN;
                    aborted_d = onehot(win_q);
                    presc_d   = '0;
                end else begin
                    grant_d = onehot(win_q);
                    if (tick_wrap) begin
                        presc_d = '0;
                        rem_d   = rem_q - DUR_W'(1);
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
            end
            ST_FIN: begin
                // Winner becomes lowest priority for the next arbitration
                ptr_d   = win_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            win_q     <= '0;
            presc_q   <= '0;
            rem_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            aborted_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Scoreboard bench for timer_share_ctrl (TICK_DIV = 10, 4 channels).
// Stimulus pushes expected output events (kind, value, cycle) into a queue;
// the negedge monitor detects events on the DUT outputs and pops/compares.
module tb_timer_share_ctrl;

    localparam int K_GRANT   = 0;
    localparam int K_GFALL   = 1;
    localparam int K_DONE    = 2;
    localparam int K_ABORT   = 3;
    localparam int K_BUSYOFF = 4;

    typedef struct {
        int       kind;
        logic [3:0] val;
        int       cyc;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] dur;
    logic        abort;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  aborted;

    ev_t  exp_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] prev_grant = '0;
    logic       prev_busy  = 1'b0;

    timer_share_ctrl #(
        .CLK_HZ (100),
        .TICK_HZ(10),
        .N_REQ  (4),
        .DUR_W  (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .dur    (dur),
        .abort  (abort),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_GRANT:   return "grant_rise";
            K_GFALL:   return "grant_fall";
            K_DONE:    return "done";
            K_ABORT:   return "aborted";
            K_BUSYOFF: return "busy_fall";
            default:   return "unknown";
        endcase
    endfunction

    task automatic push(input int kind, input logic [3:0] val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Expected events for a hold of d ticks on channel ch sampled at edge e
    task automatic hold(input int ch, input int d, input int e);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        if (d == 0) begin
            push(K_DONE, oh, e);
            push(K_BUSYOFF, 4'b0000, e + 1);
        end else begin
            push(K_GRANT, oh, e);
            push(K_GFALL, 4'b0000, e + d*10);
            push(K_DONE, oh, e + d*10);
            push(K_BUSYOFF, 4'b0000, e + d*10 + 1);
        end
    endtask

    task automatic mon_check(input int kind, input logic [3:0] val);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got val=%b at cyc=%0d, required no event",
                     kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: got %s val=%b cyc=%0d, required %s val=%b cyc=%0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Monitor: turn output activity into events, compared against the scoreboard
    always @(negedge clk) begin
        if (grant != prev_grant && grant != 4'b0000) mon_check(K_GRANT, grant);
        if (grant == 4'b0000 && prev_grant != 4'b0000) mon_check(K_GFALL, 4'b0000);
        if (done != 4'b0000) mon_check(K_DONE, done);
        if (aborted != 4'b0000) mon_check(K_ABORT, aborted);
        if (!busy && prev_busy) mon_check(K_BUSYOFF, 4'b0000);
        prev_grant <= grant;
        prev_busy  <= busy;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int e, e3, e0b;
        rst_n = 1'b0;
        req   = '0;
        dur   = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_grant", grant, 4'b0000);
        check_now("reset_busy", {3'b000, busy}, 4'b0000);
        check_now("reset_done", done, 4'b0000);
        check_now("reset_aborted", aborted, 4'b0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, ch2 for 3 ticks
        req = 4'b0100;
        dur[2*16 +: 16] = 16'd3;
        e = cyc + 1;
        hold(2, 3, e);
        wait_cyc(e + 30);
        req = 4'b0000;
        wait_cyc(e + 34);

        // All four from reset, 1 tick each: order 0,1,2,3 with 2-cycle gaps
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) dur[i*16 +: 16] = 16'd1;
        req = 4'b1111;
        e = cyc + 1;
        for (int k = 0; k < 4; k++) hold(k, 1, e + 12*k);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(e + 12*k + 10);
            req[k] = 1'b0;
        end
        wait_cyc(e + 50);

        // Zero duration on ch1: done one cycle after sample, no grant
        dur[1*16 +: 16] = 16'd0;
        req = 4'b0010;
        e = cyc + 1;
        hold(1, 0, e);
        wait_cyc(e);
        req = 4'b0000;
        wait_cyc(e + 4);

        // Abort at hold cycle 17 of a 5-tick hold on ch0
        dur[0 +: 16] = 16'd5;
        req = 4'b0001;
        e = cyc + 1;
        push(K_GRANT, 4'b0001, e);
        push(K_GFALL, 4'b0000, e + 17);
        push(K_ABORT, 4'b0001, e + 17);
        push(K_BUSYOFF, 4'b0000, e + 18);
        wait_cyc(e + 16);
        abort = 1'b1;
        wait_cyc(e + 17);
        abort = 1'b0;
        req = 4'b0000;
        wait_cyc(e + 21);

        // Same hold, cancelled by dropping req[0] instead
        req = 4'b0001;
        e = cyc + 1;
        push(K_GRANT, 4'b0001, e);
        push(K_GFALL, 4'b0000, e + 17);
        push(K_ABORT, 4'b0001, e + 17);
        push(K_BUSYOFF, 4'b0000, e + 18);
        wait_cyc(e + 16);
        req = 4'b0000;
        wait_cyc(e + 21);

        // Abort coincident with the terminal cycle: completion wins
        dur[0 +: 16] = 16'd2;
        req = 4'b0001;
        e = cyc + 1;
        hold(0, 2, e);
        wait_cyc(e + 19);
        abort = 1'b1;
        wait_cyc(e + 20);
        abort = 1'b0;
        req = 4'b0000;
        wait_cyc(e + 24);

        // Abort while idle, including the sampling edge, is ignored
        abort = 1'b1;
        repeat (2) @(negedge clk);
        dur[3*16 +: 16] = 16'd1;
        req = 4'b1000;
        e = cyc + 1;
        hold(3, 1, e);
        wait_cyc(e);
        abort = 1'b0;
        wait_cyc(e + 10);
        req = 4'b0000;
        wait_cyc(e + 14);

        // ch0 held high, ch3 arrives mid-hold: ch0, ch3, ch0; then reset mid-hold
        req = 4'b0001;
        e = cyc + 1;
        e3 = e + 22;
        e0b = e3 + 12;
        hold(0, 2, e);
        hold(3, 1, e3);
        push(K_GRANT, 4'b0001, e0b);
        push(K_GFALL, 4'b0000, e0b + 6);
        push(K_BUSYOFF, 4'b0000, e0b + 6);
        wait_cyc(e + 5);
        req[3] = 1'b1;
        wait_cyc(e3 + 10);
        req[3] = 1'b0;
        wait_cyc(e0b + 5);
        #2 rst_n = 1'b0;
        #1;
        check_now("async_reset_grant", grant, 4'b0000);
        check_now("async_reset_busy", {3'b000, busy}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        req = 4'b1001;
        rst_n = 1'b1;
        e = cyc + 1;
        hold(0, 2, e);
        hold(3, 1, e + 22);
        wait_cyc(e + 20);
        req[0] = 1'b0;
        wait_cyc(e + 32);
        req[3] = 1'b0;
        wait_cyc(e + 38);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d events never seen, required 0 (next %s cyc=%0d)",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
